// File: rtl/point_scalar_mul_ctrl_if.sv
// Curve point payload type plus the two port bundles of point_scalar_mul_ctrl.
//   psm_req_if : scalar-multiply request/result bundle.
//                master = requester (MSM bucket logic), slave = controller.
//                start, k, P -> controller; busy, done, R, R_inf <- controller.
//   psm_add_if : point_add adapter bundle.
//                master = controller, slave = adapter.
//                add_reset, add_P, add_Q -> adapter; add_done, add_R <- adapter.

package point_scalar_mul_ctrl_pkg;
  localparam int unsigned COORD_W = 256;

  // Affine point; all-zero doubles as "no point" on idle/reset buses.
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } curve_point_t;
endpackage

interface psm_req_if #(
  parameter int unsigned SCALAR_W = 256
);
  import point_scalar_mul_ctrl_pkg::*;

  logic                start;
  logic [SCALAR_W-1:0] k;
  curve_point_t        P;
  logic                busy;
  logic                done;
  curve_point_t        R;
  logic                R_inf;

  modport master (output start, k, P, input busy, done, R, R_inf);
  modport slave  (input start, k, P, output busy, done, R, R_inf);
endinterface

interface psm_add_if;
  import point_scalar_mul_ctrl_pkg::*;

  logic         add_reset;
  curve_point_t add_P;
  curve_point_t add_Q;
  logic         add_done;
  curve_point_t add_R;

  modport master (output add_reset, add_P, add_Q, input add_done, add_R);
  modport slave  (input add_reset, add_P, add_Q, output add_done, add_R);
endinterface

// File: rtl/point_scalar_mul_ctrl.sv
// point_scalar_mul_ctrl: computes R = k*P with a left-to-right double-and-add
// schedule, driving one shared point_add adapter (auto add/double select).
// Ports:
//   clk      rising-edge clock
//   Reset_n  synchronous active-low reset
//   req      psm_req_if.slave  : start/k/P in, busy/done/R/R_inf out (registered)
//   add      psm_add_if.master : add_reset/add_P/add_Q out (registered),
//                                add_done/add_R in
// Build option: SCALAR_MUL_CONST_TIME_EN makes the schedule independent of k
// (always DBL+ADD for every bit below the MSB, unused results discarded).

module point_scalar_mul_ctrl #(
  parameter int unsigned SCALAR_W = 256
) (
  input logic       clk,
  input logic       Reset_n,
  psm_req_if.slave  req,
  psm_add_if.master add
);
  import point_scalar_mul_ctrl_pkg::*;

  localparam int unsigned IDX_W = $clog2(SCALAR_W);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_NEXT, S_DBL, S_RE_D, S_ADD, S_RE_A, S_DONE
  } state_t;

  state_t              state_q, state_d;
  curve_point_t        base_q, base_d;
  logic [SCALAR_W-1:0] k_sh_q, k_sh_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  curve_point_t        acc_q, acc_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  curve_point_t        r_q, r_d;
  logic                r_inf_q, r_inf_d;
  logic                add_reset_q, add_reset_d;
  curve_point_t        add_p_q, add_p_d;
  curve_point_t        add_q_q, add_q_d;
`ifdef SCALAR_MUL_CONST_TIME_EN
  logic                acc_vld_q, acc_vld_d;
`endif

  logic k_msb;
  assign k_msb = k_sh_q[SCALAR_W-1];

  // Next-state, datapath and registered-output next values.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    k_sh_d  = k_sh_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    r_d     = r_q;
    r_inf_d = r_inf_q;
    add_p_d = add_p_q;
    add_q_d = add_q_q;
`ifdef SCALAR_MUL_CONST_TIME_EN
    acc_vld_d = acc_vld_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req.start) begin
          base_d  = req.P;
          k_sh_d  = req.k;
          idx_d   = IDX_W'(SCALAR_W - 1);
          r_inf_d = 1'b0;
          acc_d   = '0;
`ifdef SCALAR_MUL_CONST_TIME_EN
          acc_vld_d = 1'b0;
`endif
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
`ifdef SCALAR_MUL_CONST_TIME_EN
        // Only the MSB is looked at here; lower bits go through DBL/ADD.
        if (k_msb) begin
          acc_d     = base_q;
          acc_vld_d = 1'b1;
        end
        state_d = S_NEXT;
`else
        if (k_msb) begin
          acc_d   = base_q;
          state_d = S_NEXT;
        end else if (idx_q == '0) begin
          r_inf_d = 1'b1;
          r_d     = '0;
          state_d = S_DONE;
        end else begin
          k_sh_d = k_sh_q << 1;
          idx_d  = idx_q - IDX_W'(1);
        end
`endif
      end

      S_NEXT: begin
        if (idx_q == '0) begin
`ifdef SCALAR_MUL_CONST_TIME_EN
          r_d     = acc_vld_q ? acc_q : '0;
          r_inf_d = !acc_vld_q;
`else
          r_d = acc_q;
`endif
          state_d = S_DONE;
        end else begin
          k_sh_d  = k_sh_q << 1;
          idx_d   = idx_q - IDX_W'(1);
          add_p_d = acc_q;
          add_q_d = acc_q;
          state_d = S_DBL;
        end
      end

      S_DBL: begin
        if (add.add_done) begin
`ifdef SCALAR_MUL_CONST_TIME_EN
          if (acc_vld_q) acc_d = add.add_R;
`else
          acc_d = add.add_R;
`endif
          state_d = S_RE_D;
        end
      end

      S_RE_D: begin
`ifdef SCALAR_MUL_CONST_TIME_EN
        add_p_d = acc_q;
        add_q_d = base_q;
        state_d = S_ADD;
`else
        if (k_msb) begin
          add_p_d = acc_q;
          add_q_d = base_q;
          state_d = S_ADD;
        end else begin
          state_d = S_NEXT;
        end
`endif
      end

      S_ADD: begin
        if (add.add_done) begin
`ifdef SCALAR_MUL_CONST_TIME_EN
          // Keep the sum only for a set bit on a valid acc; the first set
          // bit seeds acc with the base point instead.
          if (k_msb) begin
            if (acc_vld_q) begin
              acc_d = add.add_R;
            end else begin
              acc_d     = base_q;
              acc_vld_d = 1'b1;
            end
          end
`else
          acc_d = add.add_R;
`endif
          state_d = S_RE_A;
        end
      end

      S_RE_A: state_d = S_NEXT;

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // Outputs registered from the next state so they line up with it.
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    add_reset_d = !((state_d == S_DBL) || (state_d == S_ADD));
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      k_sh_q      <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      r_q         <= '0;
      r_inf_q     <= 1'b0;
      add_reset_q <= 1'b1;
      add_p_q     <= '0;
      add_q_q     <= '0;
`ifdef SCALAR_MUL_CONST_TIME_EN
      acc_vld_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      k_sh_q      <= k_sh_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      r_q         <= r_d;
      r_inf_q     <= r_inf_d;
      add_reset_q <= add_reset_d;
      add_p_q     <= add_p_d;
      add_q_q     <= add_q_d;
`ifdef SCALAR_MUL_CONST_TIME_EN
      acc_vld_q   <= acc_vld_d;
`endif
    end
  end

  assign req.busy      = busy_q;
  assign req.done      = done_q;
  assign req.R         = r_q;
  assign req.R_inf     = r_inf_q;
  assign add.add_reset = add_reset_q;
  assign add.add_P     = add_p_q;
  assign add.add_Q     = add_q_q;

endmodule

// File: tb/tb_point_scalar_mul_ctrl.sv
// Testbench for point_scalar_mul_ctrl with an 8-bit scalar and a toy additive
// group (points are n*(x0,y0) with componentwise addition) behind a fixed
// latency adapter model.

module tb_point_scalar_mul_ctrl;
  import point_scalar_mul_ctrl_pkg::*;

  localparam int unsigned W     = 8;
  localparam int unsigned LAT   = 3;
  localparam int          BOUND = 2000;
`ifdef SCALAR_MUL_CONST_TIME_EN
  localparam int unsigned CT_OPS = 2 * (W - 1);
`endif

  logic clk = 1'b0;
  logic Reset_n;

  psm_req_if #(.SCALAR_W(W)) req ();
  psm_add_if                 add ();

  point_scalar_mul_ctrl #(.SCALAR_W(W)) dut (
    .clk     (clk),
    .Reset_n (Reset_n),
    .req     (req),
    .add     (add)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  function automatic curve_point_t mk(input int unsigned x, input int unsigned y);
    curve_point_t p;
    p.x = COORD_W'(x);
    p.y = COORD_W'(y);
    return p;
  endfunction

  function automatic curve_point_t pt_add(input curve_point_t a, input curve_point_t b);
    curve_point_t r;
    r.x = a.x + b.x;
    r.y = a.y + b.y;
    return r;
  endfunction

  curve_point_t G, H, ZERO;
  initial begin
    G    = mk(5, 7);
    H    = mk(11, 13);
    ZERO = mk(0, 0);
  end

  // Adapter model: Done + result LAT cycles after Reset drops.
  int unsigned  acnt = 0;
  int unsigned  op_cnt = 0;
  logic         op_dbl [256];
  curve_point_t op_p   [256];
  always @(posedge clk) begin
    if (add.add_reset) begin
      acnt         <= 0;
      add.add_done <= 1'b0;
      add.add_R    <= '0;
    end else begin
      acnt <= acnt + 1;
      if (acnt == LAT - 1) begin
        add.add_done             <= 1'b1;
        add.add_R                <= pt_add(add.add_P, add.add_Q);
        op_dbl[op_cnt[7:0]]      <= (add.add_P == add.add_Q);
        op_p[op_cnt[7:0]]        <= add.add_P;
        op_cnt                   <= op_cnt + 1;
      end
    end
  end

  // Adapter-bus monitor: low-run length, operand stability, low-run count.
  logic         prev_rst = 1'b1;
  curve_point_t prev_p, prev_q;
  int unsigned  low_len = 0;
  int unsigned  low_runs = 0;
  int unsigned  bad_run = 0;
  int unsigned  unstable = 0;
  always @(posedge clk) begin
    if (!add.add_reset) begin
      low_len <= low_len + 1;
      if (prev_rst) low_runs <= low_runs + 1;
      else if ((add.add_P !== prev_p) || (add.add_Q !== prev_q)) unstable <= unstable + 1;
    end else begin
      if (!prev_rst && (low_len != LAT + 1)) bad_run <= bad_run + 1;
      low_len <= 0;
    end
    prev_rst <= add.add_reset;
    prev_p   <= add.add_P;
    prev_q   <= add.add_Q;
  end

  // Issue one request and wait for done; lat = negedges from start to done.
  task automatic run_op(input logic [W-1:0] kk, input curve_point_t pp,
                        output int lat, output int busy_gaps);
    lat = -1;
    busy_gaps = 0;
    @(negedge clk);
    req.start = 1'b1;
    req.k     = kk;
    req.P     = pp;
    @(negedge clk);
    req.start = 1'b0;
    req.k     = ~kk;
    req.P     = H;
    for (int c = 1; c <= BOUND; c++) begin
      if (c > 1) @(negedge clk);
      if (req.done === 1'b1) begin
        lat = c;
        break;
      end
      if (req.busy !== 1'b1) busy_gaps++;
    end
  endtask

  task automatic test_reset;
    Reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (req.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", req.busy); end
    checks++; if (req.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", req.done); end
    checks++; if (req.R !== ZERO) begin failures++; $display("FAIL reset_R got=%h exp=0", req.R); end
    checks++; if (req.R_inf !== 1'b0) begin failures++; $display("FAIL reset_R_inf got=%b exp=0", req.R_inf); end
    checks++; if (add.add_reset !== 1'b1) begin failures++; $display("FAIL reset_add_reset got=%b exp=1", add.add_reset); end
    checks++; if ((add.add_P !== ZERO) || (add.add_Q !== ZERO)) begin failures++; $display("FAIL reset_operands got=%h/%h exp=0", add.add_P, add.add_Q); end
    Reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_k0;
    int lat, gaps;
    int unsigned ops0, runs0;
    ops0 = op_cnt; runs0 = low_runs;
    run_op(8'h00, G, lat, gaps);
`ifdef SCALAR_MUL_CONST_TIME_EN
    checks++; if (op_cnt - ops0 != CT_OPS) begin failures++; $display("FAIL k0_ops got=%0d exp=%0d", op_cnt - ops0, CT_OPS); end
    checks++; if (lat < 0) begin failures++; $display("FAIL k0_timeout got=%0d exp=done", lat); end
`else
    checks++; if (lat != W + 1) begin failures++; $display("FAIL k0_latency got=%0d exp=%0d", lat, W + 1); end
    checks++; if (op_cnt - ops0 != 0) begin failures++; $display("FAIL k0_ops got=%0d exp=0", op_cnt - ops0); end
    checks++; if (low_runs - runs0 != 0) begin failures++; $display("FAIL k0_add_reset_low got=%0d exp=0", low_runs - runs0); end
`endif
    checks++; if (req.R_inf !== 1'b1) begin failures++; $display("FAIL k0_R_inf got=%b exp=1", req.R_inf); end
    checks++; if (req.R !== ZERO) begin failures++; $display("FAIL k0_R got=%h exp=0", req.R); end
    checks++; if (gaps != 0) begin failures++; $display("FAIL k0_busy got=%0d gaps exp=0", gaps); end
  endtask

  int lat_k1 = -1;

  task automatic test_k1;
    int lat, gaps;
    int unsigned ops0;
    ops0 = op_cnt;
    run_op(8'h01, G, lat, gaps);
    lat_k1 = lat;
    checks++; if (lat < 0) begin failures++; $display("FAIL k1_timeout got=%0d exp=done", lat); end
    checks++; if (req.R !== G) begin failures++; $display("FAIL k1_R got=%h exp=%h", req.R, G); end
    checks++; if (req.R_inf !== 1'b0) begin failures++; $display("FAIL k1_R_inf got=%b exp=0", req.R_inf); end
`ifdef SCALAR_MUL_CONST_TIME_EN
    checks++; if (op_cnt - ops0 != CT_OPS) begin failures++; $display("FAIL k1_ops got=%0d exp=%0d", op_cnt - ops0, CT_OPS); end
`else
    checks++; if (op_cnt - ops0 != 0) begin failures++; $display("FAIL k1_ops got=%0d exp=0", op_cnt - ops0); end
`endif
    @(negedge clk);
    checks++; if (req.busy !== 1'b0) begin failures++; $display("FAIL k1_busy_after got=%b exp=0", req.busy); end
    checks++; if (req.done !== 1'b0) begin failures++; $display("FAIL k1_done_pulse got=%b exp=0", req.done); end
    checks++; if (req.R !== G) begin failures++; $display("FAIL k1_R_hold got=%h exp=%h", req.R, G); end
  endtask

  task automatic test_k2;
    int lat, gaps;
    int unsigned ops0;
    ops0 = op_cnt;
    run_op(8'h02, G, lat, gaps);
    checks++; if (req.R !== mk(10, 14)) begin failures++; $display("FAIL k2_R got=%h exp=%h", req.R, mk(10, 14)); end
`ifndef SCALAR_MUL_CONST_TIME_EN
    checks++; if (op_cnt - ops0 != 1) begin failures++; $display("FAIL k2_ops got=%0d exp=1", op_cnt - ops0); end
    checks++; if ((op_dbl[ops0[7:0]] !== 1'b1) || (op_p[ops0[7:0]] !== G)) begin
      failures++; $display("FAIL k2_dbl_operand got=%b/%h exp=1/%h", op_dbl[ops0[7:0]], op_p[ops0[7:0]], G);
    end
`else
    checks++; if (op_cnt - ops0 != CT_OPS) begin failures++; $display("FAIL k2_ops got=%0d exp=%0d", op_cnt - ops0, CT_OPS); end
`endif
  endtask

  task automatic test_kB;
    int lat, gaps;
    int unsigned ops0, bad0, uns0;
    logic [4:0] seq;
    ops0 = op_cnt; bad0 = bad_run; uns0 = unstable;
    run_op(8'h0B, G, lat, gaps);
    checks++; if (req.R !== mk(55, 77)) begin failures++; $display("FAIL kB_R got=%h exp=%h", req.R, mk(55, 77)); end
    checks++; if (bad_run - bad0 != 0) begin failures++; $display("FAIL kB_handshake got=%0d bad runs exp=0", bad_run - bad0); end
    checks++; if (unstable - uns0 != 0) begin failures++; $display("FAIL kB_operand_stable got=%0d exp=0", unstable - uns0); end
    checks++; if (gaps != 0) begin failures++; $display("FAIL kB_busy got=%0d gaps exp=0", gaps); end
`ifdef SCALAR_MUL_CONST_TIME_EN
    checks++; if (op_cnt - ops0 != CT_OPS) begin failures++; $display("FAIL kB_ops got=%0d exp=%0d", op_cnt - ops0, CT_OPS); end
    checks++; if ((lat < 0) || (lat != lat_k1)) begin failures++; $display("FAIL kB_const_latency got=%0d exp=%0d", lat, lat_k1); end
`else
    checks++; if (op_cnt - ops0 != 5) begin failures++; $display("FAIL kB_ops got=%0d exp=5", op_cnt - ops0); end
    for (int i = 0; i < 5; i++) seq[4-i] = op_dbl[8'(ops0 + i)];
    checks++; if (seq !== 5'b11010) begin failures++; $display("FAIL kB_sequence got=%b exp=11010 (1=DBL)", seq); end
`endif
  endtask

  task automatic test_reset_mid;
    int lat, gaps, waited;
    int unsigned ops0, runs0;
    ops0 = op_cnt; runs0 = low_runs;
    @(negedge clk);
    req.start = 1'b1; req.k = 8'h0B; req.P = G;
    @(negedge clk);
    req.start = 1'b0;
    waited = 0;
    while (((low_runs - runs0) < 2 || add.add_reset !== 1'b0) && waited < BOUND) begin
      @(negedge clk);
      waited++;
    end
    checks++; if (waited >= BOUND) begin failures++; $display("FAIL mid_reach_second_op got=timeout exp=second op"); end
    Reset_n = 1'b0;
    @(negedge clk);
    checks++; if ((add.add_reset !== 1'b1) || (req.busy !== 1'b0)) begin
      failures++; $display("FAIL mid_reset_abort got=add_reset %b busy %b exp=1/0", add.add_reset, req.busy);
    end
    Reset_n = 1'b1;
    repeat (2) @(negedge clk);
    ops0 = op_cnt;
    run_op(8'h03, H, lat, gaps);
    checks++; if (req.R !== mk(33, 39)) begin failures++; $display("FAIL mid_restart_R got=%h exp=%h", req.R, mk(33, 39)); end
    checks++; if (req.R_inf !== 1'b0) begin failures++; $display("FAIL mid_restart_R_inf got=%b exp=0", req.R_inf); end
`ifdef SCALAR_MUL_CONST_TIME_EN
    checks++; if (op_cnt - ops0 != CT_OPS) begin failures++; $display("FAIL mid_restart_ops got=%0d exp=%0d", op_cnt - ops0, CT_OPS); end
`else
    checks++; if (op_cnt - ops0 != 2) begin failures++; $display("FAIL mid_restart_ops got=%0d exp=2", op_cnt - ops0); end
`endif
  endtask

  task automatic test_start_while_busy;
    int waited;
    int unsigned ops0;
    ops0 = op_cnt;
    @(negedge clk);
    req.start = 1'b1; req.k = 8'h05; req.P = G;
    @(negedge clk);
    req.start = 1'b0;
    repeat (3) @(negedge clk);
    req.start = 1'b1; req.k = 8'h0B; req.P = H;
    @(negedge clk);
    req.start = 1'b0;
    waited = 0;
    while (req.done !== 1'b1 && waited < BOUND) begin
      @(negedge clk);
      waited++;
    end
    checks++; if (waited >= BOUND) begin failures++; $display("FAIL busy_start_timeout got=timeout exp=done"); end
    checks++; if (req.R !== mk(25, 35)) begin failures++; $display("FAIL busy_start_R got=%h exp=%h", req.R, mk(25, 35)); end
`ifdef SCALAR_MUL_CONST_TIME_EN
    checks++; if (op_cnt - ops0 != CT_OPS) begin failures++; $display("FAIL busy_start_ops got=%0d exp=%0d", op_cnt - ops0, CT_OPS); end
`else
    checks++; if (op_cnt - ops0 != 3) begin failures++; $display("FAIL busy_start_ops got=%0d exp=3", op_cnt - ops0); end
`endif
    repeat (3) @(negedge clk);
    checks++; if (req.busy !== 1'b0) begin failures++; $display("FAIL busy_start_idle got=%b exp=0", req.busy); end
  endtask

  initial begin
    Reset_n   = 1'b0;
    req.start = 1'b0;
    req.k     = '0;
    req.P     = '0;
    test_reset();
    test_k0();
    test_k1();
    test_k2();
    test_kB();
    test_reset_mid();
    test_start_while_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
